cv32e40p_apu_issue: RTL and testbench

//  Core-side APU master. Accepts decoded FP ops, drives the APU req/gnt request channel,

---
 rtl/cv32e40p_apu_core_pkg.sv | 28 ++
 rtl/cv32e40p_apu_tag_fifo.sv | 53 +++++
 rtl/cv32e40p_apu_issue.sv | 163 ++++++++++++++++
 tb/tb_cv32e40p_apu_issue.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU types and widths for the core-side APU issue logic.
package cv32e40p_apu_core_pkg;

    localparam int APU_NARGS_CPU    = 3;
    localparam int APU_WOP_CPU      = 6;
    localparam int APU_NDSFLAGS_CPU = 15;
    localparam int APU_NUSFLAGS_CPU = 5;
    localparam int APU_RD_W_CPU     = 5;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } apu_issue_state_e;

    typedef struct packed {
        logic [APU_NARGS_CPU-1:0][31:0]  operands;
        logic [APU_WOP_CPU-1:0]          op;
        logic [APU_NDSFLAGS_CPU-1:0]     flags;
        logic [APU_RD_W_CPU-1:0]         rd;
    } apu_req_t;

    // A source register of x0 never creates a dependency.
    function automatic logic rd_hit(input logic [APU_RD_W_CPU-1:0] rs,
                                    input logic [APU_RD_W_CPU-1:0] rd);
        return (rs != '0) && (rs == rd);
    endfunction

endpackage

// File: rtl/cv32e40p_apu_tag_fifo.sv
// Circular FIFO of destination-register tags for granted, not-yet-returned APU ops.
// Exposes every slot plus a valid mask so the issue logic can compare all tags at once.
module cv32e40p_apu_tag_fifo #(
    parameter  int DEPTH = 4,
    parameter  int RD_W  = 5,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic                  pop,
    input  logic [RD_W-1:0]       wdata,
    output logic [RD_W-1:0]       head,
    output logic [CNT_W-1:0]      count,
    output logic [DEPTH*RD_W-1:0] entries,
    output logic [DEPTH-1:0]      valid
);

    logic [RD_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

    // A slot is live when its distance from the read pointer is below the occupancy.
    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign entries[i*RD_W +: RD_W] = mem[i];
        assign valid[i] = {1'b0, PTR_W'(i) - rd_ptr} < count;
    end

endmodule

// File: rtl/cv32e40p_apu_issue.sv
// Core-side APU master: request channel, in-order tag tracking, registered writeback,
// sticky fflags and protocol error flag.
// Optional feature macro: CV32E40P_APU_ISSUE_HAZARD_EN (RAW stall against in-flight rds).
//
// state | meaning
// IDLE  | no request pending on the APU channel
// REQ   | request register holds an op, apu_req_o high until granted
module cv32e40p_apu_issue
    import cv32e40p_apu_core_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int RD_W  = APU_RD_W_CPU
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 issue_valid_i,
    output logic                                 issue_ready_o,
    input  logic [APU_NARGS_CPU-1:0][31:0]       issue_operands_i,
    input  logic [APU_WOP_CPU-1:0]               issue_op_i,
    input  logic [APU_NDSFLAGS_CPU-1:0]          issue_flags_i,
    input  logic [RD_W-1:0]                      issue_rd_i,
    input  logic [APU_NARGS_CPU-1:0][RD_W-1:0]   issue_rs_i,
    output logic                                 apu_req_o,
    input  logic                                 apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]       apu_operands_o,
    output logic [APU_WOP_CPU-1:0]               apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]          apu_flags_o,
    input  logic                                 apu_rvalid_i,
    input  logic [31:0]                          apu_rdata_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]          apu_rflags_i,
    output logic                                 wb_valid_o,
    output logic [RD_W-1:0]                      wb_rd_o,
    output logic [31:0]                          wb_rdata_o,
    output logic [4:0]                           fflags_o,
    input  logic                                 fflags_clr_i,
    output logic                                 busy_o,
    output logic                                 err_o
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    apu_issue_state_e     state;
    apu_req_t             req_q;
    logic [CNT_W-1:0]     count;
    logic [RD_W-1:0]      fifo_head;
    logic [DEPTH*RD_W-1:0] fifo_entries;
    logic [DEPTH-1:0]     fifo_valid;
    logic                 hazard;
    logic                 pop;
    logic                 gnt_ok;
    logic                 accept;
    logic                 pending_hold;

    assign pop = apu_rvalid_i && (count != '0);

    // A grant is only honoured when the tag FIFO can take it, so a misbehaving
    // responder can never overflow the tracker.
    assign gnt_ok = (state == REQ) && apu_gnt_i && ((count < CNT_W'(DEPTH)) || pop);

    assign pending_hold  = (state == REQ) && !gnt_ok;
    assign issue_ready_o = ((state == IDLE) || gnt_ok)
                        && ((count + {{(CNT_W-1){1'b0}}, pending_hold}) < CNT_W'(DEPTH))
                        && !hazard;
    assign accept = issue_valid_i && issue_ready_o;

`ifdef CV32E40P_APU_ISSUE_HAZARD_EN
    // Stall when any source register matches an in-flight or pending destination.
    always_comb begin
        hazard = 1'b0;
        for (int a = 0; a < APU_NARGS_CPU; a++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (fifo_valid[e] && rd_hit(issue_rs_i[a], fifo_entries[e*RD_W +: RD_W]))
                    hazard = 1'b1;
            end
            if ((state == REQ) && rd_hit(issue_rs_i[a], req_q.rd))
                hazard = 1'b1;
        end
    end
`else
    // RAW interlock is left to the core scoreboard in this build.
    logic unused_hazard_inputs;
    assign unused_hazard_inputs = ^{issue_rs_i, fifo_entries, fifo_valid};
    assign hazard = 1'b0;
`endif

    // Request FSM: loads the request register on accept, drops apu_req_o once granted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            apu_req_o <= 1'b0;
            req_q     <= '0;
        end else begin
            if (accept) begin
                req_q.operands <= issue_operands_i;
                req_q.op       <= issue_op_i;
                req_q.flags    <= issue_flags_i;
                req_q.rd       <= issue_rd_i;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= REQ;
                        apu_req_o <= 1'b1;
                    end
                end
                REQ: begin
                    if (gnt_ok && !accept) begin
                        state     <= IDLE;
                        apu_req_o <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    apu_req_o <= 1'b0;
                end
            endcase
        end
    end

    assign apu_operands_o = req_q.operands;
    assign apu_op_o       = req_q.op;
    assign apu_flags_o    = req_q.flags;

    cv32e40p_apu_tag_fifo #(
        .DEPTH (DEPTH),
        .RD_W  (RD_W)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push    (gnt_ok),
        .pop     (pop),
        .wdata   (req_q.rd),
        .head    (fifo_head),
        .count   (count),
        .entries (fifo_entries),
        .valid   (fifo_valid)
    );

    // Registered writeback, sticky accrued flags and sticky orphan-result error.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_o <= 1'b0;
            wb_rd_o    <= '0;
            wb_rdata_o <= '0;
            fflags_o   <= '0;
            err_o      <= 1'b0;
        end else begin
            wb_valid_o <= pop;
            if (pop) begin
                wb_rd_o    <= fifo_head;
                wb_rdata_o <= apu_rdata_i;
            end
            if (apu_rvalid_i && (count == '0)) err_o <= 1'b1;
            if (fflags_clr_i)
                fflags_o <= apu_rvalid_i ? apu_rflags_i : 5'h00;
            else if (apu_rvalid_i)
                fflags_o <= fflags_o | apu_rflags_i;
        end
    end

    assign busy_o = apu_req_o || (count != '0);

endmodule

// File: tb/tb_cv32e40p_apu_issue.sv
// Self-checking bench for cv32e40p_apu_issue against a queue-based transaction model.
module tb_cv32e40p_apu_issue;

    localparam int DEPTH = 4;
    localparam int RD_W  = 5;
    localparam int NARGS = 3;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       issue_valid_i;
    logic                       issue_ready_o;
    logic [NARGS-1:0][31:0]     issue_operands_i;
    logic [5:0]                 issue_op_i;
    logic [14:0]                issue_flags_i;
    logic [RD_W-1:0]            issue_rd_i;
    logic [NARGS-1:0][RD_W-1:0] issue_rs_i;
    logic                       apu_req_o;
    logic                       apu_gnt_i;
    logic [NARGS-1:0][31:0]     apu_operands_o;
    logic [5:0]                 apu_op_o;
    logic [14:0]                apu_flags_o;
    logic                       apu_rvalid_i;
    logic [31:0]                apu_rdata_i;
    logic [4:0]                 apu_rflags_i;
    logic                       wb_valid_o;
    logic [RD_W-1:0]            wb_rd_o;
    logic [31:0]                wb_rdata_o;
    logic [4:0]                 fflags_o;
    logic                       fflags_clr_i;
    logic                       busy_o;
    logic                       err_o;

    cv32e40p_apu_issue #(.DEPTH(DEPTH), .RD_W(RD_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .issue_operands_i(issue_operands_i), .issue_op_i(issue_op_i),
        .issue_flags_i(issue_flags_i), .issue_rd_i(issue_rd_i), .issue_rs_i(issue_rs_i),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_rdata_i(apu_rdata_i), .apu_rflags_i(apu_rflags_i),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_rdata_o(wb_rdata_o),
        .fflags_o(fflags_o), .fflags_clr_i(fflags_clr_i),
        .busy_o(busy_o), .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one optional pending op plus an in-order queue of granted rds.
    logic [RD_W-1:0]        m_q[$];
    bit                     m_pend;
    logic [NARGS-1:0][31:0] m_ops;
    logic [5:0]             m_op;
    logic [14:0]            m_fl;
    logic [RD_W-1:0]        m_rd;
    bit                     m_wb_v;
    logic [RD_W-1:0]        m_wb_rd;
    logic [31:0]            m_wb_data;
    logic [4:0]             m_ff;
    bit                     m_err;
    bit                     m_acc;

    function automatic void chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_pend = 0; m_ops = '0; m_op = '0; m_fl = '0; m_rd = '0;
        m_wb_v = 0; m_wb_rd = '0; m_wb_data = '0; m_ff = '0; m_err = 0;
    endfunction

    function automatic bit model_hazard(input logic [NARGS-1:0][RD_W-1:0] rs);
        bit h = 0;
`ifdef CV32E40P_APU_ISSUE_HAZARD_EN
        for (int a = 0; a < NARGS; a++) begin
            if (rs[a] != 0) begin
                foreach (m_q[k]) if (m_q[k] == rs[a]) h = 1;
                if (m_pend && m_rd == rs[a]) h = 1;
            end
        end
`else
        h = (rs === 'x);
`endif
        return h;
    endfunction

    // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
    task automatic step(input bit v, input logic [RD_W-1:0] rd, input logic [NARGS-1:0][RD_W-1:0] rs,
                        input bit g, input bit rv, input logic [31:0] rdat,
                        input logic [4:0] rf, input bit clr);
        bit gok, exp_ready, pop;
        int occ;
        issue_valid_i    = v;
        issue_rd_i       = rd;
        issue_rs_i       = rs;
        issue_operands_i = {$urandom, $urandom, $urandom};
        issue_op_i       = 6'($urandom);
        issue_flags_i    = 15'($urandom);
        apu_gnt_i        = g;
        apu_rvalid_i     = rv;
        apu_rdata_i      = rdat;
        apu_rflags_i     = rf;
        fflags_clr_i     = clr;
        @(negedge clk_i);
        gok       = m_pend && g;
        occ       = m_q.size() + ((m_pend && !gok) ? 1 : 0);
        exp_ready = (!m_pend || gok) && (occ < DEPTH) && !model_hazard(rs);
        chk("issue_ready", issue_ready_o, exp_ready);
        chk("apu_req", apu_req_o, m_pend);
        if (m_pend) begin
            chk("apu_operands", apu_operands_o, m_ops);
            chk("apu_op", apu_op_o, m_op);
            chk("apu_flags", apu_flags_o, m_fl);
        end
        chk("wb_valid", wb_valid_o, m_wb_v);
        if (m_wb_v) begin
            chk("wb_rd", wb_rd_o, m_wb_rd);
            chk("wb_rdata", wb_rdata_o, m_wb_data);
        end
        chk("fflags", fflags_o, m_ff);
        chk("busy", busy_o, m_pend || m_q.size() != 0);
        chk("err", err_o, m_err);
        // model update
        pop    = rv && m_q.size() != 0;
        if (rv && m_q.size() == 0) m_err = 1;
        m_wb_v = pop;
        if (pop) begin
            m_wb_rd   = m_q.pop_front();
            m_wb_data = rdat;
        end
        if (gok) m_q.push_back(m_rd);
        if (clr) m_ff = rv ? rf : 5'h00;
        else if (rv) m_ff = m_ff | rf;
        m_acc = v && exp_ready;
        if (m_acc) begin
            m_pend = 1; m_ops = issue_operands_i; m_op = issue_op_i;
            m_fl = issue_flags_i; m_rd = rd;
        end else if (gok) begin
            m_pend = 0;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        issue_valid_i = 0; apu_gnt_i = 0; apu_rvalid_i = 0; fflags_clr_i = 0;
        issue_rd_i = '0; issue_rs_i = '0; issue_operands_i = '0; issue_op_i = '0;
        issue_flags_i = '0; apu_rdata_i = '0; apu_rflags_i = '0;
        rst_i = 1;
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 0;
        model_reset();
    endtask

    initial begin
        do_reset();
        // Reset state: every output low.
        chk("rst_req", apu_req_o, 0);
        chk("rst_wb_valid", wb_valid_o, 0);
        chk("rst_fflags", fflags_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_operands", apu_operands_o, 0);
        idle(2);

        // Test 1: single op rd=3, grant on first request cycle, result two cycles later.
        step(1, 3, '0, 0, 0, 0, 0, 0);
        chk("t1_req_after_accept", apu_req_o, 1);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        idle(1);
        step(0, 0, '0, 0, 1, 32'h3F800000, 5'h01, 0);
        chk("t1_wb_valid", wb_valid_o, 1);
        chk("t1_wb_rd", wb_rd_o, 3);
        chk("t1_wb_rdata", wb_rdata_o, 32'h3F800000);
        chk("t1_fflags", fflags_o, 5'h01);
        chk("t1_busy", busy_o, 0);
        idle(1);
        chk("t1_wb_pulse", wb_valid_o, 0);

        // Test 2: grant withheld for 3 cycles.
        step(1, 4, '0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 5, '0, 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        chk("t2_req_dropped", apu_req_o, 0);
        step(0, 0, '0, 0, 1, 32'h1234, 5'h00, 0);
        idle(1);

        // Test 3: five back-to-back ops, responder grants only while it has room.
        for (int i = 0; i < 5; i++) step(1, 5'(10 + i), '0, 1, 0, 0, 0, 0);
        idle(1);
        chk("t3_full_ready", issue_ready_o, 0);
        chk("t3_pending_req", apu_req_o, 1);
        step(1, 20, '0, 1, 1, 32'hA, 5'h02, 0);
        chk("t3_pending_granted", apu_req_o, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 1, 32'(i), 5'h00, 0);
        idle(1);
        chk("t3_drained", busy_o, 0);

        // Test 4: rd 1,2,3 in flight, rd 9 pending, results in order; rvalid with gnt keeps count.
        step(1, 1, '0, 0, 0, 0, 0, 0);
        step(1, 2, '0, 1, 0, 0, 0, 0);
        step(1, 3, '0, 1, 0, 0, 0, 0);
        step(1, 9, '0, 1, 0, 0, 0, 0);
        step(0, 0, '0, 1, 1, 32'h11, 5'h00, 0);
        chk("t4_wb_rd_1", wb_rd_o, 1);
        step(0, 0, '0, 0, 1, 32'h22, 5'h00, 0);
        chk("t4_wb_rd_2", wb_rd_o, 2);
        step(0, 0, '0, 0, 1, 32'h33, 5'h00, 0);
        chk("t4_wb_rd_3", wb_rd_o, 3);
        step(0, 0, '0, 0, 1, 32'h99, 5'h00, 0);
        chk("t4_wb_rd_9", wb_rd_o, 9);
        idle(1);

        // Randomized traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            logic [NARGS-1:0][RD_W-1:0] rs;
            for (int a = 0; a < NARGS; a++) rs[a] = ($urandom_range(0, 2) == 0) ? RD_W'($urandom) : '0;
            step($urandom_range(0, 2) != 0, RD_W'($urandom_range(1, 12)), rs,
                 (m_q.size() < DEPTH) ? bit'($urandom_range(0, 1)) : 1'b0,
                 (m_q.size() != 0) ? ($urandom_range(0, 2) == 0) : 1'b0,
                 $urandom, 5'($urandom), $urandom_range(0, 15) == 0);
        end

        // Reset mid-operation, then a late result must flag err without writeback.
        step(1, 6, '0, 0, 0, 0, 0, 0);
        do_reset();
        chk("t5_rst_busy", busy_o, 0);
        step(0, 0, '0, 1, 1, 32'hDEAD, 5'h04, 0);
        chk("t5_err", err_o, 1);
        chk("t5_no_wb", wb_valid_o, 0);
        step(0, 0, '0, 0, 1, 32'h0, 5'h10, 1);
        chk("t5_clr_rvalid", fflags_o, 5'h10);
        step(0, 0, '0, 0, 0, 0, 0, 1);
        chk("t5_clr_alone", fflags_o, 5'h00);

        // Test 6: source matching an in-flight rd (stalls only with the hazard build).
        do_reset();
        step(1, 7, '0, 0, 0, 0, 0, 0);
        step(1, 8, {5'd0, 5'd0, 5'd7}, 1, 0, 0, 0, 0);
        step(1, 8, {5'd0, 5'd7, 5'd0}, 0, 0, 0, 0, 0);
        step(1, 8, {5'd0, 5'd0, 5'd0}, 0, 0, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0, 0, 0);
        step(1, 9, {5'd7, 5'd0, 5'd0}, 0, 1, 32'h7, 5'h00, 0);
        step(1, 9, {5'd7, 5'd0, 5'd0}, 1, 0, 0, 0, 0);
        step(0, 0, '0, 1, 1, 32'h8, 5'h00, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 1, m_q.size() != 0, 32'h9, 5'h00, 0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
